text_console_ctrl: RTL

- Character-terminal front end that turns a byte stream of ASCII plus control codes into 16-bit text VRAM writes.
- Tracks the hardware cursor and generates the cursor blink clock for the downstream VGA text/graphics mixer.
- Sits between the CPU/IO bus and the VRAM write port. The VGA stage reads the same VRAM and consumes `cursor` and `blink` directly.
- Layout is fixed at 8x8 font, 640x480 (80x60 cells); VRAM address = row*80 + col.

---
 rtl/text_console_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/text_console_ctrl.sv
// text_console_ctrl: byte stream to 80x60 text VRAM writes, with the cursor and the blink clock
module text_console_ctrl #(
  parameter int COLS      = 80,
  parameter int ROWS      = 60,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  input  logic [7:0]  attr,
  output logic        ch_ready,
  output logic        vram_we,
  output logic [12:0] vram_addr,
  output logic [15:0] vram_din,
  output logic [12:0] cursor,
  output logic        blink,
  output logic        busy
);
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  typedef enum logic [1:0] {IDLE, PUT, CLR_LINE, CLR_SCR} state_t;
  state_t state_q, state_d;
  logic [5:0] row_q, row_d;
  logic [6:0] col_q, col_d, ch_q, ch_d;
  logic [7:0] attr_q, attr_d;
  logic adv_q, adv_d;
  logic [12:0] clr_q, clr_d, base;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic blink_q, blink_d, last_row, last_col, bwrap;
  always_comb begin
    base = {1'b0, row_q, 6'b0} + {3'b0, row_q, 4'b0};
    last_row = row_q == 6'(ROWS - 1);
    last_col = col_q == 7'(COLS - 1);
    bwrap = bcnt_q == BW'(BLINK_DIV - 1);
    bcnt_d = bwrap ? '0 : bcnt_q + 1'b1;
    blink_d = blink_q ^ bwrap;
    state_d = state_q;
    row_d = row_q;
    col_d = col_q;
    ch_d = ch_q;
    attr_d = attr_q;
    adv_d = adv_q;
    clr_d = clr_q;
    case (state_q)
      IDLE: if (ch_valid) begin
        attr_d = attr;
        if (ch_data >= 8'h20 && ch_data <= 8'h7e) begin
          ch_d = ch_data[6:0];
          adv_d = 1'b1;
          state_d = PUT;
        end else if (ch_data == 8'h0d) begin
          col_d = '0;
        end else if (ch_data == 8'h0a) begin
          col_d = '0;
          row_d = last_row ? '0 : row_q + 1'b1;
          state_d = last_row ? CLR_LINE : IDLE;
        end else if (ch_data == 8'h08 && col_q != '0) begin
          col_d = col_q - 1'b1;
          ch_d = 7'h20;
          adv_d = 1'b0;
          state_d = PUT;
        end else if (ch_data == 8'h0c) begin
          row_d = '0;
          col_d = '0;
          state_d = CLR_SCR;
        end
      end
      PUT: begin
        state_d = IDLE;
        if (adv_q) begin
          col_d = last_col ? '0 : col_q + 1'b1;
          if (last_col) begin
            row_d = last_row ? '0 : row_q + 1'b1;
            state_d = last_row ? CLR_LINE : IDLE;
          end
        end
      end
      CLR_LINE: begin
        clr_d = clr_q == 13'(COLS - 1) ? '0 : clr_q + 1'b1;
        state_d = clr_q == 13'(COLS - 1) ? IDLE : CLR_LINE;
      end
      default: begin
        clr_d = clr_q == 13'(COLS * ROWS - 1) ? '0 : clr_q + 1'b1;
        state_d = clr_q == 13'(COLS * ROWS - 1) ? IDLE : CLR_SCR;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q <= '0;
      col_q <= '0;
      ch_q <= '0;
      attr_q <= '0;
      adv_q <= 1'b0;
      clr_q <= '0;
      bcnt_q <= '0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      col_q <= col_d;
      ch_q <= ch_d;
      attr_q <= attr_d;
      adv_q <= adv_d;
      clr_q <= clr_d;
      bcnt_q <= bcnt_d;
      blink_q <= blink_d;
    end
  end
  // Write port is driven straight from the state so each cell gets exactly one strobe
  assign ch_ready = state_q == IDLE;
  assign busy = state_q == CLR_LINE || state_q == CLR_SCR;
  assign vram_we = state_q != IDLE;
  assign vram_addr = state_q == PUT ? base + {6'b0, col_q} :
                     state_q == CLR_LINE ? base + clr_q :
                     state_q == CLR_SCR ? clr_q : '0;
  assign vram_din = state_q == IDLE ? '0 : {attr_q, 1'b0, state_q == PUT ? ch_q : 7'h20};
  assign cursor = {row_q, col_q};
  assign blink = blink_q;
endmodule
